// File: rtl/link_stall_monitor.sv
// link_stall_monitor: passive observer on one NoC link. Parses packets,
// measures dead cycles inside a packet, pulses an alarm when a mid-packet
// stall reaches STALL_THRESHOLD and reports the stalled packet's identity.
module link_stall_monitor #(
  parameter logic [15:0]  ADDRESS         = 16'b0,
  parameter string        PORT            = "",
  parameter int unsigned  STALL_THRESHOLD = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  input  logic        cr_i,
  input  logic        eop_i,
  input  logic [31:0] data_i,
  output logic        alarm_o,
  output logic        alarm_delivery_o,
  output logic [15:0] alarm_sender_o,
  output logic [15:0] alarm_receiver_o,
  output logic [31:0] alarm_timestamp_o,
  output logic        done_o,
  output logic [15:0] max_stall_o,
  output logic [15:0] alarm_count_o
);

  // Service code of MESSAGE_DELIVERY, mirrored from TaskInjectorPkg.
  localparam logic [7:0]  MESSAGE_DELIVERY = 8'h02;
  localparam int unsigned CNT_W            = 16;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR_M1      = CNT_W'(STALL_THRESHOLD - 1);
  localparam bit          HAS_PORT_NAME    = (PORT != "");

  // Threshold must fit the 16-bit stall counter and be non-zero.
  if (STALL_THRESHOLD < 1 || STALL_THRESHOLD > 65535) begin : g_bad_threshold
    $error("link_stall_monitor: STALL_THRESHOLD must be in 1..65535");
  end

  // ADDRESS and PORT only identify the instance; nothing in the datapath uses them.
  logic unused_id;
  assign unused_id = ^{ADDRESS, HAS_PORT_NAME};

  typedef enum logic [2:0] {
    S_HEADER    = 3'd0,
    S_SRCPE     = 3'd1,
    S_EDGE      = 3'd2,
    S_TIMESTAMP = 3'd3,
    S_PAYLOAD   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [7:0]        service_q;
  logic [15:0]       sender_q, receiver_q;
  logic [31:0]       timestamp_q;
  logic [CNT_W-1:0]  stall_cnt_q, max_stall_q;
  logic              flagged_q;

  logic              xfer;
  logic              in_packet;
  logic              hdr_xfer, edge_xfer, ts_xfer, eop_xfer;
  logic              is_delivery;
  logic              alarm_fire;
  logic [CNT_W-1:0]  max_next;

  assign xfer = rx_i && cr_i;

  // Parser state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_HEADER;
    else         state_q <= state_d;
  end

  // Next-state: advance on transfers; an EOP transfer always resyncs to HEADER.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      case (state_q)
        S_HEADER:    state_d = S_SRCPE;
        S_SRCPE:     state_d = (service_q == MESSAGE_DELIVERY) ? S_EDGE : S_PAYLOAD;
        S_EDGE:      state_d = S_TIMESTAMP;
        S_TIMESTAMP: state_d = S_PAYLOAD;
        S_PAYLOAD:   state_d = S_PAYLOAD;
        default:     state_d = S_HEADER;
      endcase
      if (eop_i) state_d = S_HEADER;
    end
  end

  // Decode of the current state and link activity into strobes.
  always_comb begin
    in_packet   = (state_q != S_HEADER);
    hdr_xfer    = xfer && (state_q == S_HEADER);
    edge_xfer   = xfer && (state_q == S_EDGE);
    ts_xfer     = xfer && (state_q == S_TIMESTAMP);
    eop_xfer    = xfer && eop_i;
    is_delivery = (service_q == MESSAGE_DELIVERY);
    alarm_fire  = in_packet && !xfer && !flagged_q && (stall_cnt_q == THR_M1);
    max_next    = (stall_cnt_q > max_stall_q) ? stall_cnt_q : max_stall_q;
  end

  // Packet identity fields; cleared at each header so stale values never leak.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      service_q   <= '0;
      sender_q    <= '0;
      receiver_q  <= '0;
      timestamp_q <= '0;
    end else if (hdr_xfer) begin
      service_q   <= data_i[23:16];
      sender_q    <= '0;
      receiver_q  <= '0;
      timestamp_q <= '0;
    end else if (edge_xfer) begin
      sender_q    <= data_i[31:16];
      receiver_q  <= data_i[15:0];
    end else if (ts_xfer) begin
      timestamp_q <= data_i;
    end
  end

  // Dead-cycle run length, per-packet maximum and one-alarm-per-packet flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      max_stall_q <= '0;
      flagged_q   <= 1'b0;
    end else begin
      if (!in_packet || xfer)        stall_cnt_q <= '0;
      else if (stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_W'(1);

      if (hdr_xfer) max_stall_q <= '0;
      else          max_stall_q <= max_next;

      if (hdr_xfer || eop_xfer) flagged_q <= 1'b0;
      else if (alarm_fire)      flagged_q <= 1'b1;
    end
  end

  // Registered report outputs; fields hold until the next alarm / done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alarm_o           <= 1'b0;
      alarm_delivery_o  <= 1'b0;
      alarm_sender_o    <= '0;
      alarm_receiver_o  <= '0;
      alarm_timestamp_o <= '0;
      alarm_count_o     <= '0;
      done_o            <= 1'b0;
      max_stall_o       <= '0;
    end else begin
      alarm_o <= alarm_fire;
      done_o  <= eop_xfer && flagged_q;
      if (alarm_fire) begin
        alarm_delivery_o  <= is_delivery;
        alarm_sender_o    <= is_delivery ? sender_q    : 16'h0;
        alarm_receiver_o  <= is_delivery ? receiver_q  : 16'h0;
        alarm_timestamp_o <= is_delivery ? timestamp_q : 32'h0;
        if (alarm_count_o != CNT_MAX) alarm_count_o <= alarm_count_o + CNT_W'(1);
      end
      if (eop_xfer && flagged_q) max_stall_o <= max_next;
    end
  end

endmodule

// File: doc/link_stall_monitor.md
# link_stall_monitor

Passive observer on one directional NoC link, placed on the downstream side of a link fault injector, between it and the receiving router port. Parses each packet crossing the link, counts dead cycles inside a packet, raises a one-cycle alarm when a mid-packet stall reaches a threshold, and reports the stalled packet's identity and stall length for the injector's hang events to be cross-checked. It never drives the link and adds no latency.

## Interface
- ADDRESS, 16'b0, router address (x in [15:8], y in [7:0]); identification only
- PORT, "", port name string; identification only
- STALL_THRESHOLD, 64, dead cycles inside a packet that trigger an alarm; must be 1..65535, elaboration error otherwise

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- rx_i  in  1  link valid seen by receiver
- cr_i  in  1  receiver credit/ready on the link
- eop_i  in  1  end-of-packet flag of current flit
- data_i  in  32  flit data
- alarm_o  out  1  one-cycle pulse: stall reached STALL_THRESHOLD
- alarm_delivery_o  out  1  alarmed packet is a MESSAGE_DELIVERY (valid with alarm_o)
- alarm_sender_o  out  16  edge sender of alarmed packet; 0 if not delivery
- alarm_receiver_o  out  16  edge receiver of alarmed packet; 0 if not delivery
- alarm_timestamp_o  out  32  timestamp flit of alarmed packet; 0 if not delivery
- done_o  out  1  one-cycle pulse at EOP transfer of a packet that alarmed
- max_stall_o  out  16  longest dead-cycle run of that packet (valid with done_o)
- alarm_count_o  out  16  alarms since reset, saturates at 16'hFFFF

## Operation
- Transfer (xfer) = rx_i && cr_i. Only transfers advance the parser.
- FSM states HEADER, SRCPE, EDGE, TIMESTAMP, PAYLOAD; reset to HEADER.
- HEADER: on xfer latch service = data_i[23:16] -> SRCPE.
- SRCPE: on xfer -> EDGE if service == MESSAGE_DELIVERY (TaskInjectorPkg), else PAYLOAD.
- EDGE: on xfer latch sender = data_i[31:16], receiver = data_i[15:0] -> TIMESTAMP.
- TIMESTAMP: on xfer latch timestamp = data_i -> PAYLOAD.
- PAYLOAD: waits for EOP.
- xfer with eop_i = 1 in any state -> HEADER (overrides above); short/truncated packets resync.
- in_packet = (state != HEADER). Alarm is always qualified by in_packet; stalls between packets are never counted.
- stall_cnt (16 b): cleared on any xfer and while in HEADER; else +1 per cycle, saturating at 16'hFFFF.
- max_stall (16 b): cleared on header xfer; updated to stall_cnt when stall_cnt exceeds it.
- flagged: set when alarm fires, cleared on header xfer; at most one alarm per packet.
- Fields of a non-delivery packet report as 0; delivery fields latched after the alarm are not re-reported.

## Timing
- All outputs registered; reset values all 0, including alarm_count_o.
- alarm_o high in the cycle where stall_cnt equals STALL_THRESHOLD, i.e. registered from (in_packet && !xfer && !flagged && stall_cnt == STALL_THRESHOLD-1). Alarm fields update in the same cycle and hold until the next alarm.
- alarm_count_o increments in the cycle alarm_o is high.
- done_o: registered from (xfer && eop_i && flagged); max_stall_o is the final max_stall, including the run ending at this transfer; holds until the next done_o.
- xfer in the same cycle as threshold crossing: xfer wins, counter clears, no alarm.
- Alarm in TIMESTAMP before the timestamp flit: alarm_timestamp_o = 0, alarm_sender_o/receiver_o valid.
- Reset mid-packet: state HEADER, all counters and flags cleared; the next flit is parsed as a header.
- Monitor has no effect on rx_i/cr_i; back-pressure stalls (rx_i=1, cr_i=0) and hang stalls (rx_i=0) count alike.

## Test plan
- Delivery packet (header service=MESSAGE_DELIVERY, srcpe, edge 0x0102_0003, ts 1000, 2 payload, EOP) with no gaps -> no alarm, done_o never high, alarm_count_o = 0.
- Same packet with 70-cycle gap after timestamp flit, THRESHOLD=64 -> alarm_o exactly 64 cycles after last xfer, sender 0x0102, receiver 0x0003, timestamp 1000; done_o at EOP with max_stall_o = 70; count = 1.
- Non-delivery packet stalled 100 cycles mid-payload -> alarm_delivery_o = 0, fields 0, single alarm.
- Gap of exactly 63 cycles, then xfer on cycle 64 -> no alarm; max_stall not reported.
- Two stalls of 80 cycles in one packet -> one alarm only, max_stall_o = 80 at EOP.
- rst_ni low for 1 cycle mid-stall at count 40 -> outputs 0; next flit treated as header, new packet parsed correctly.
